// File: rtl/bram_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_loader_pkg
// Shared constants and types for the BRAM stream loader.
//   DEF_ADDR_W : default word-address width (memory depth 2**DEF_ADDR_W)
//   DEF_DATA_W : default data width (multiple of 8)
//   state_t    : control FSM states
// -----------------------------------------------------------------------------
package bram_stream_loader_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/bram_stream_loader_chk.sv
// -----------------------------------------------------------------------------
// bram_stream_loader_chk
// Readback checker: delays each written beat alongside a port-A read of the
// same address, compares the returned word on the enabled bytes only, and
// keeps the sticky error flag, first-error address and saturating error count.
// Only built when BRAM_STREAM_LOADER_READBACK_EN is defined.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 accepted start: wipe error bookkeeping
//   in_valid/addr/data/strb  stage-0 beat (the registered port-B write)
//   mem_addr_a            registered port-A read address
//   mem_q_a               port-A read data (one cycle after address sampled)
//   busy                  a beat is still in flight inside the checker
//   err, err_addr, err_cnt  error reporting
// -----------------------------------------------------------------------------
module bram_stream_loader_chk
    import bram_stream_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [BE_W-1:0]   in_strb,
    output logic [ADDR_W-1:0] mem_addr_a,
    input  logic [DATA_W-1:0] mem_q_a,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   err_cnt
);

    logic              v1_reg, v2_reg;
    logic [ADDR_W-1:0] addr_a_reg, addr2_reg;
    logic [DATA_W-1:0] exp1_reg, exp2_reg;
    logic [BE_W-1:0]   strb1_reg, strb2_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] err_addr_reg;
    logic [ADDR_W:0]   err_cnt_reg;
    logic [DATA_W-1:0] byte_mask;
    logic              mismatch;

    // Expand the delayed strobe to a bit mask so unwritten bytes are ignored.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_mask
            assign byte_mask[gi*8 +: 8] = {8{strb2_reg[gi]}};
        end
    endgenerate

    assign mismatch = v2_reg && (|((mem_q_a ^ exp2_reg) & byte_mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            addr_a_reg   <= '0;
            addr2_reg    <= '0;
            exp1_reg     <= '0;
            exp2_reg     <= '0;
            strb1_reg    <= '0;
            strb2_reg    <= '0;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            // Stage 1: present the address to port A one cycle after the
            // port-B write register, so the read never collides with the write.
            v1_reg <= in_valid;
            if (in_valid) begin
                addr_a_reg <= in_addr;
                exp1_reg   <= in_data;
                strb1_reg  <= in_strb;
            end
            // Stage 2: memory samples addr_a; keep expectations aligned.
            v2_reg    <= v1_reg;
            addr2_reg <= addr_a_reg;
            exp2_reg  <= exp1_reg;
            strb2_reg <= strb1_reg;
            // Stage 3: compare result lands in the error bookkeeping.
            if (clear) begin
                err_reg      <= 1'b0;
                err_addr_reg <= '0;
                err_cnt_reg  <= '0;
            end else if (mismatch) begin
                err_reg <= 1'b1;
                if (!err_reg) begin
                    err_addr_reg <= addr2_reg;
                end
                if (err_cnt_reg != '1) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign mem_addr_a = addr_a_reg;
    assign busy       = v1_reg | v2_reg;
    assign err        = err_reg;
    assign err_addr   = err_addr_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: rtl/bram_stream_loader.sv
// -----------------------------------------------------------------------------
// bram_stream_loader
// Writes a valid/ready word stream into a contiguous (wrapping) window of a
// dual-port BRAM through its byte-write port B. With the optional macro
// BRAM_STREAM_LOADER_READBACK_EN defined, every written word is read back
// through port A and compared on the enabled bytes.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, base_addr, count   transfer request (sampled in IDLE only)
//   s_valid, s_data, s_strb, s_ready   input stream
//   mem_we_b, mem_addr_b, mem_din_b    registered port-B write
//   mem_addr_a, mem_q_a                port-A readback
//   busy, done                         transfer status
//   err, err_addr, err_cnt             readback error reporting
// -----------------------------------------------------------------------------
module bram_stream_loader
    import bram_stream_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [BE_W-1:0]   s_strb,
    output logic              s_ready,
    output logic [BE_W-1:0]   mem_we_b,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [DATA_W-1:0] mem_din_b,
    output logic [ADDR_W-1:0] mem_addr_a,
    input  logic [DATA_W-1:0] mem_q_a,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   err_cnt
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W:0]   remaining_reg;
    logic [BE_W-1:0]   we_reg;
    logic [ADDR_W-1:0] addr_b_reg;
    logic [DATA_W-1:0] din_b_reg;
    logic              v0_reg;      // a beat sits in the port-B write register
    logic              fresh_reg;   // first cycle spent in DRAIN
    logic              done_reg;
    logic              start_ok, beat, last_beat, pipe_empty, drain_done;

    assign start_ok  = start && (state_reg == IDLE);
    assign s_ready   = (state_reg == WRITE) && (remaining_reg != '0);
    assign beat      = s_valid && s_ready;
    assign last_beat = beat && (remaining_reg == (ADDR_W+1)'(1));

`ifdef BRAM_STREAM_LOADER_READBACK_EN
    logic chk_busy;

    bram_stream_loader_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .in_valid   (v0_reg),
        .in_addr    (addr_b_reg),
        .in_data    (din_b_reg),
        .in_strb    (we_reg),
        .mem_addr_a (mem_addr_a),
        .mem_q_a    (mem_q_a),
        .busy       (chk_busy),
        .err        (err),
        .err_addr   (err_addr),
        .err_cnt    (err_cnt)
    );

    assign pipe_empty = !v0_reg && !chk_busy;
`else
    logic unused_q;
    assign unused_q   = ^mem_q_a;
    assign mem_addr_a = '0;
    assign err        = 1'b0;
    assign err_addr   = '0;
    assign err_cnt    = '0;
    assign pipe_empty = !v0_reg;
`endif

    // Holding DRAIN for at least one full cycle keeps an empty transfer's
    // done pulse two cycles after start, same as a write-only drain.
    assign drain_done = (state_reg == DRAIN) && !fresh_reg && pipe_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? DRAIN : WRITE;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            remaining_reg <= '0;
            we_reg        <= '0;
            addr_b_reg    <= '0;
            din_b_reg     <= '0;
            v0_reg        <= 1'b0;
            fresh_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            we_reg    <= beat ? s_strb : '0;
            v0_reg    <= beat;
            fresh_reg <= (state_reg != DRAIN) && (state_next == DRAIN);
            done_reg  <= drain_done;
            if (start_ok) begin
                ptr_reg       <= base_addr;
                remaining_reg <= count;
            end else if (beat) begin
                addr_b_reg    <= ptr_reg;
                din_b_reg     <= s_data;
                ptr_reg       <= ptr_reg + ADDR_W'(1);   // wraps at the top
                remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
            end
        end
    end

    assign mem_we_b   = we_reg;
    assign mem_addr_b = addr_b_reg;
    assign mem_din_b  = din_b_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

endmodule

// File: tb/tb_bram_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_loader
// Bench for bram_stream_loader with a behavioural dual-port BRAM model and a
// reference memory image / write list computed from the transfer rules.
// Honours BRAM_STREAM_LOADER_READBACK_EN for latency and error expectations.
// -----------------------------------------------------------------------------
module tb_bram_stream_loader;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef BRAM_STREAM_LOADER_READBACK_EN
    localparam bit RB  = 1'b1;
    localparam int LAT = 4;
`else
    localparam bit RB  = 1'b0;
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [BW-1:0] s_strb = '0;
    logic          s_ready;
    logic [BW-1:0] mem_we_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_din_b;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] mem_q_a;
    logic          busy, done, err;
    logic [AW-1:0] err_addr;
    logic [AW:0]   err_cnt;

    int compared = 0;
    int failed   = 0;

    bram_stream_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_strb     (s_strb),
        .s_ready    (s_ready),
        .mem_we_b   (mem_we_b),
        .mem_addr_b (mem_addr_b),
        .mem_din_b  (mem_din_b),
        .mem_addr_a (mem_addr_a),
        .mem_q_a    (mem_q_a),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- BRAM model (port B byte write, port A registered read)
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            inject = 1'b0;
    bit            mem_clear = 1'b0;
    bit            pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else begin
            for (int b = 0; b < BW; b++)
                if (mem_we_b[b]) mem[mem_addr_b][b*8 +: 8] <= mem_din_b[b*8 +: 8];
        end
        mem_q_a <= mem[mem_addr_a] ^ ((inject && mem_addr_a == AW'(5)) ? 32'h8 : 32'h0);
    end

    // ---------------- monitors
    int cyc = 0;
    int done_pulses = 0;
    logic [AW+BW-1:0] wlog [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses <= done_pulses + 1;
        if (|mem_we_b) wlog.push_back({mem_addr_b, mem_we_b});
    end

    // ---------------- reference model
    logic [DW-1:0]    tx_data [$];
    logic [BW-1:0]    tx_strb [$];
    logic [AW+BW-1:0] exp_wlog [$];
    logic             exp_err;
    logic [AW-1:0]    exp_err_addr;
    int               exp_err_cnt;

    task automatic gen_beats(input int n, input bit rand_strb);
        tx_data.delete();
        tx_strb.delete();
        for (int i = 0; i < n; i++) begin
            tx_data.push_back($urandom);
            tx_strb.push_back(rand_strb ? BW'($urandom_range(0, (1 << BW) - 1)) : '1);
        end
    endtask

    // Beat i lands at (base+i) mod depth; only its enabled bytes change.
    // A readback error is expected wherever the flipped bit (bit 3, byte 0)
    // of address 5 was actually written.
    task automatic model_transfer(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        exp_wlog.delete();
        exp_err = 1'b0;
        exp_err_addr = '0;
        exp_err_cnt = 0;
        for (int i = 0; i < n; i++) begin
            a = AW'((int'(b) + i) % DEPTH);
            for (int k = 0; k < BW; k++)
                if (tx_strb[i][k]) ref_mem[a][k*8 +: 8] = tx_data[i][k*8 +: 8];
            if (tx_strb[i] != '0) exp_wlog.push_back({a, tx_strb[i]});
            if (RB && inject && a == AW'(5) && tx_strb[i][0]) begin
                if (!exp_err) exp_err_addr = a;
                exp_err = 1'b1;
                exp_err_cnt++;
            end
        end
    endtask

    // ---------------- driver
    // gap_pct < 0 means s_valid toggles every cycle, starting high.
    task automatic run_transfer(input logic [AW-1:0] b, input int n, input int gap_pct,
                                output int last_edge, output int done_edge,
                                output bit ready_after, output int we_bad, output bit tmo);
        int idx = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit prev_acc = 1'b0;
        logic [BW-1:0] prev_strb = '0;
        wlog.delete();
        we_bad = 0;
        tmo = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = b; count = (AW+1)'(n);
        last_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (idx < n && guard < 20000) begin
            if (mem_we_b !== (prev_acc ? prev_strb : '0)) we_bad++;
            s_valid = (gap_pct < 0) ? phase : ($urandom_range(0, 99) >= gap_pct);
            phase = ~phase;
            s_data = tx_data[idx];
            s_strb = tx_strb[idx];
            prev_acc = s_valid && s_ready;
            prev_strb = s_strb;
            if (prev_acc) begin
                idx++;
                last_edge = cyc + 1;
            end
            guard++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        ready_after = s_ready;
        if (idx < n) tmo = 1'b1;
        guard = 0;
        while (done !== 1'b1 && guard < 60) begin
            if (mem_we_b !== (prev_acc ? prev_strb : '0)) we_bad++;
            prev_acc = 1'b0;
            guard++;
            @(negedge clk);
        end
        if (done !== 1'b1) tmo = 1'b1;
        done_edge = cyc;
        $display("xfer base=%03h count=%0d beats_sent=%0d last_beat_edge=%0d done_edge=%0d err=%0b err_addr=%03h err_cnt=%0d",
                 b, n, idx, last_edge, done_edge, err, err_addr, err_cnt);
    endtask

    // ---------------- tests
    int le, de, wb;
    bit ra, tm;

    task automatic test_reset();
        logic [BW+AW+DW+AW+AW+AW+5:0] outs;
        #2 rst_n = 1'b0;
        mem_clear = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(negedge clk);
        outs = {s_ready, mem_we_b, mem_addr_b, mem_din_b, mem_addr_a, busy, done, err, err_addr, err_cnt};
        compared++;
        if (outs !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        @(negedge clk);
        mem_clear = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        int bad = 0;
        tx_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tx_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        model_transfer(AW'(0), 4);
        run_transfer(AW'(0), 4, 0, le, de, ra, wb, tm);
        compared++;
        if (tm || (de - le) != LAT) begin
            failed++;
            $display("FAIL basic_latency: got %0d (timeout=%0b) required %0d", de - le, tm, LAT);
        end
        compared++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL basic_busy_at_done: got %b required 0", busy);
        end
        for (int i = 0; i < 4; i++) if (mem[i] !== (32'h11111111 * (i + 1))) bad++;
        compared++;
        if (bad != 0 || wlog.size() != 4) begin
            failed++;
            $display("FAIL basic_writes: got %0d bad words, %0d writes required 0 bad, 4 writes", bad, wlog.size());
        end
        compared++;
        if (err !== 1'b0) begin
            failed++;
            $display("FAIL basic_err: got %b required 0", err);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            failed++;
            $display("FAIL basic_done_width: got %b required 0", done);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        gen_beats(3, 1'b0);
        model_transfer(AW'('h10), 3);
        run_transfer(AW'('h10), 3, -1, le, de, ra, wb, tm);
        for (int i = 0; i < 3; i++)
            if (i >= wlog.size() || wlog[i][AW+BW-1:BW] !== AW'('h10 + i)) bad++;
        compared++;
        if (bad != 0 || wlog.size() != 3) begin
            failed++;
            $display("FAIL bubble_addresses: got %0d bad of %0d writes required 0 bad of 3", bad, wlog.size());
        end
        compared++;
        if (wb != 0) begin
            failed++;
            $display("FAIL bubble_we_gaps: got %0d bad cycles required 0", wb);
        end
        compared++;
        if (ra !== 1'b0) begin
            failed++;
            $display("FAIL bubble_ready_after_last: got %b required 0", ra);
        end
        compared++;
        if (tm || (de - le) != LAT) begin
            failed++;
            $display("FAIL bubble_latency: got %0d (timeout=%0b) required %0d", de - le, tm, LAT);
        end
    endtask

    task automatic test_strobes();
        @(negedge clk);
        pre_en = 1'b1; pre_addr = AW'(7); pre_data = 32'h12345678;
        ref_mem[7] = 32'h12345678;
        @(negedge clk);
        pre_en = 1'b0;
        tx_data = '{32'hAABBCCDD};
        tx_strb = '{4'b0101};
        model_transfer(AW'(7), 1);
        run_transfer(AW'(7), 1, 0, le, de, ra, wb, tm);
        compared++;
        if (mem[7] !== 32'h12BB56DD) begin
            failed++;
            $display("FAIL strobe_merge: got %h required 12bb56dd", mem[7]);
        end
        compared++;
        if (tm || err !== 1'b0) begin
            failed++;
            $display("FAIL strobe_err: got %b (timeout=%0b) required 0", err, tm);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want [4];
        int bad = 0;
        want = '{AW'('h3FE), AW'('h3FF), AW'('h000), AW'('h001)};
        gen_beats(4, 1'b0);
        model_transfer(AW'('h3FE), 4);
        run_transfer(AW'('h3FE), 4, 20, le, de, ra, wb, tm);
        for (int i = 0; i < 4; i++)
            if (i >= wlog.size() || wlog[i][AW+BW-1:BW] !== want[i]) bad++;
        compared++;
        if (tm || bad != 0 || wlog.size() != 4) begin
            failed++;
            $display("FAIL wrap_addresses: got %0d bad of %0d writes (timeout=%0b) required 0 bad of 4", bad, wlog.size(), tm);
        end
        compared++;
        if (mem[0] !== tx_data[2] || mem[1] !== tx_data[3]) begin
            failed++;
            $display("FAIL wrap_data: got %h %h required %h %h", mem[0], mem[1], tx_data[2], tx_data[3]);
        end
    endtask

    task automatic test_fault();
        inject = 1'b1;
        gen_beats(8, 1'b0);
        model_transfer(AW'(0), 8);
        run_transfer(AW'(0), 8, 0, le, de, ra, wb, tm);
        compared++;
        if (tm || err !== (RB ? 1'b1 : 1'b0) || err_addr !== (RB ? AW'(5) : AW'(0))
            || err_cnt !== (RB ? (AW+1)'(1) : (AW+1)'(0))) begin
            failed++;
            $display("FAIL fault_report: got err=%b addr=%h cnt=%0d required err=%b addr=%h cnt=%0d",
                     err, err_addr, err_cnt, RB, RB ? 5 : 0, RB ? 1 : 0);
        end
        inject = 1'b0;
        gen_beats(0, 1'b0);
        run_transfer(AW'(0), 0, 0, le, de, ra, wb, tm);
        compared++;
        if (tm || err !== 1'b0 || err_addr !== '0 || err_cnt !== '0) begin
            failed++;
            $display("FAIL fault_clear_on_start: got err=%b addr=%h cnt=%0d required all 0", err, err_addr, err_cnt);
        end
    endtask

    task automatic test_count_zero();
        gen_beats(0, 1'b0);
        run_transfer(AW'($urandom_range(0, DEPTH - 1)), 0, 0, le, de, ra, wb, tm);
        compared++;
        if (tm || (de - le) != 2 || wlog.size() != 0) begin
            failed++;
            $display("FAIL count_zero: got done %0d cycles after start, %0d writes (timeout=%0b) required 2, 0",
                     de - le, wlog.size(), tm);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        logic [BW+AW+DW+AW+AW+AW+5:0] outs;
        gen_beats(8, 1'b0);
        @(negedge clk);
        start = 1'b1; base_addr = AW'('h40); count = (AW+1)'(8);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = tx_data[i]; s_strb = '1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        p = done_pulses;
        outs = {s_ready, mem_we_b, mem_addr_b, mem_din_b, mem_addr_a, busy, done, err, err_addr, err_cnt};
        compared++;
        if (outs !== '0) begin
            failed++;
            $display("FAIL reset_mid_outputs: got %h required 0", outs);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (done_pulses != p) begin
            failed++;
            $display("FAIL reset_mid_no_done: got %0d extra pulses required 0", done_pulses - p);
        end
        // Which in-flight beats reached memory is not defined; restart the
        // reference image from the memory model's current contents.
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        gen_beats(2, 1'b0);
        model_transfer(AW'('h80), 2);
        run_transfer(AW'('h80), 2, 0, le, de, ra, wb, tm);
        compared++;
        if (tm || (de - le) != LAT || mem[128] !== tx_data[0] || mem[129] !== tx_data[1]) begin
            failed++;
            $display("FAIL reset_mid_restart: got latency %0d words %h %h (timeout=%0b) required %0d %h %h",
                     de - le, mem[128], mem[129], tm, LAT, tx_data[0], tx_data[1]);
        end
    endtask

    task automatic test_random(input int iters, input bit full);
        logic [AW-1:0] b;
        int n, bad, wbad;
        for (int it = 0; it < iters; it++) begin
            b = AW'($urandom_range(0, DEPTH - 1));
            n = full ? DEPTH : $urandom_range(1, 48);
            inject = full ? 1'b0 : 1'(($urandom_range(0, 2)) == 0);
            gen_beats(n, !full);
            model_transfer(b, n);
            run_transfer(b, n, full ? 0 : $urandom_range(0, 60), le, de, ra, wb, tm);
            wbad = 0;
            for (int i = 0; i < exp_wlog.size(); i++)
                if (i >= wlog.size() || wlog[i] !== exp_wlog[i]) wbad++;
            compared++;
            if (tm || wbad != 0 || wlog.size() != exp_wlog.size()) begin
                failed++;
                $display("FAIL rand_write_list: got %0d bad of %0d writes (timeout=%0b) required 0 bad of %0d",
                         wbad, wlog.size(), tm, exp_wlog.size());
            end
            compared++;
            if ((de - le) != LAT || wb != 0) begin
                failed++;
                $display("FAIL rand_timing: got latency %0d, %0d stray we cycles required %0d, 0", de - le, wb, LAT);
            end
            compared++;
            if (err !== exp_err || err_addr !== exp_err_addr || err_cnt !== (AW+1)'(exp_err_cnt)) begin
                failed++;
                $display("FAIL rand_err: got err=%b addr=%h cnt=%0d required err=%b addr=%h cnt=%0d",
                         err, err_addr, err_cnt, exp_err, exp_err_addr, exp_err_cnt);
            end
            @(negedge clk);
            bad = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
            compared++;
            if (bad != 0 || done !== 1'b0) begin
                failed++;
                $display("FAIL rand_memory_image: got %0d differing words, done=%b required 0, 0", bad, done);
            end
        end
        inject = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_backpressure();
        test_strobes();
        test_wrap();
        test_fault();
        test_count_zero();
        test_reset_mid();
        test_random(8, 1'b0);
        test_random(1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/bram_stream_loader.md
Name: bram_stream_loader

Overview:
- Initiator-side companion to the team's dual-port 32-bit block RAM (port A read-only, port B byte-write).
- Accepts a valid/ready word stream and writes each beat into a contiguous address window through port B.
- With readback compiled in, reads each written word back through port A and compares the written bytes, reporting errors.
- Sits between a host/DMA stream source and the BRAM instance; used for run-time load and self-check.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W.
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a transfer; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start
- count  in  ADDR_W+1  number of beats, 0..2**ADDR_W, sampled on start
- s_valid  in  1  stream beat valid
- s_data  in  DATA_W  stream beat data
- s_strb  in  BE_W  per-byte write enable for the beat
- s_ready  out  1  beat accepted when s_valid && s_ready
- mem_we_b  out  BE_W  port B byte write enables (registered)
- mem_addr_b  out  ADDR_W  port B address (registered)
- mem_din_b  out  DATA_W  port B write data (registered)
- mem_addr_a  out  ADDR_W  port A read address (registered)
- mem_q_a  in  DATA_W  port A read data, valid one cycle after mem_addr_a is sampled
- busy  out  1  transfer in progress, including pipeline drain
- done  out  1  one-cycle pulse when a transfer completes
- err  out  1  sticky mismatch flag, cleared on accepted start
- err_addr  out  ADDR_W  address of the first mismatch since start
- err_cnt  out  ADDR_W+1  saturating count of mismatching beats

Behaviour:
- Reset (async): all outputs 0; mem_we_b forced 0 immediately; state IDLE; the pipeline is flushed.
- States: IDLE -> WRITE on start with count>0; IDLE -> DRAIN on start with count==0; WRITE -> DRAIN when the last beat is accepted; DRAIN -> IDLE when the pipeline is empty, with done pulsed for 1 cycle.
- Accepted start: clears err, err_addr and err_cnt. busy rises the next cycle. start while busy is ignored.
- s_ready = (state==WRITE) && remaining>0. Combinational from state only; never depends on s_valid.
- Accepted beat at edge E0:
  - mem_we_b=s_strb, mem_addr_b=ptr, mem_din_b=s_data. Registered, so the memory writes at E1.
  - ptr increments modulo 2**ADDR_W, so addresses wrap 2**ADDR_W-1 -> 0.
  - remaining decrements.
- Cycles without an accepted beat: mem_we_b=0; addr_b and din_b hold their values.
- Beat with s_strb=0: accepted and consumes an address, but writes nothing and is never flagged.
- Readback pipeline (READBACK_EN):
  - E1: mem_addr_a takes the stage-0 address; the expected data and strobe are delayed alongside.
  - E2: memory samples addr_a.
  - E3: compare (mem_q_a ^ exp) masked per enabled byte.
  - A mismatch at E3 sets err. On the first mismatch only, err_addr is captured. err_cnt increments and saturates at all-ones.
  - Latency is 3 cycles from beat acceptance to the error update, at a throughput of 1 beat/cycle.
  - Port A is never read in the same cycle as its port-B write, so no read-during-write hazard.
- done: asserted the cycle after the last compare (READBACK_EN) or the last write. busy deasserts in the same cycle.
- count==0: no writes; done pulses 2 cycles after start.
- count==2**ADDR_W: the window covers the whole memory exactly once.
- Reset mid-transfer: in-flight beats are lost, no partial error reporting, and done does not pulse.

Optional Feature:
- Macro BRAM_STREAM_LOADER_READBACK_EN.
- Defined: the readback/compare pipeline described above.
- Undefined:
  - mem_addr_a tied to 0; err, err_addr and err_cnt tied to 0.
  - DRAIN lasts 1 cycle, so done pulses 2 cycles after the last accepted beat.

Decomposition:
- Package bram_stream_loader_pkg: default ADDR_W and DATA_W constants; state enum {IDLE, WRITE, DRAIN}.
- One sub-module, bram_stream_loader_chk: the 3-stage delay line plus masked compare and error bookkeeping. Excluded entirely when the macro is undefined.

Test Plan:
- Basic load:
  - Stimulus: base=0, count=4, back-to-back beats 0x11111111..0x44444444, strb=F.
  - Response: writes to addresses 0..3; done pulses 4 cycles after the 4th beat is accepted; err=0.
- Bubbles and backpressure:
  - Stimulus: base=0x10, count=3 with s_valid low on alternate cycles.
  - Response: addresses 0x10, 0x11, 0x12; mem_we_b=0 during gaps; s_ready drops after the 3rd beat.
- Byte strobes:
  - Stimulus: address 7 preloaded 0x12345678; beat 0xAABBCCDD with strb=0101.
  - Response: memory holds 0x12BB56DD; err=0.
- Wrap:
  - Stimulus: base=0x3FE, count=4.
  - Response: writes to 0x3FE, 0x3FF, 0x000, 0x001.
- Fault injection:
  - Stimulus: the bench memory model flips bit 3 of address 5 on readback during count=8 from 0.
  - Response: err=1, err_addr=5, err_cnt=1; the next start clears all three.
- Edge cases:
  - Stimulus: count=0; separately, rst_n low mid-WRITE.
  - Response: count=0 gives done 2 cycles after start with no writes. Reset gives all outputs 0 immediately, no done, and a fresh start works.
